// File: rtl/lsu_mem_port_pkg.sv
// lsu_defs: shared encodings for the LSU data-port initiator and its
// load-extension helper (funct3 codes, DataSize codes, response error
// codes, FSM state type and small request-decode helpers).
package lsu_defs;

   // RISC-V funct3 codes for loads/stores
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Memory DataSize encodings
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   // Response error codes
   localparam logic [1:0] ERR_OK       = 2'b00;
   localparam logic [1:0] ERR_MISALIGN = 2'b01;
   localparam logic [1:0] ERR_FUNCT3   = 2'b10;
   localparam logic [1:0] ERR_RANGE    = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_RESP = 2'd2
   } lsu_state_t;

   // Stores only support B/H/W; loads add the unsigned byte/half forms
   function automatic logic f3_legal(input logic we, input logic [2:0] f3);
      if (we)
         return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      else
         return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                (f3 == F3_BU) || (f3 == F3_HU);
   endfunction

   // Access width in bytes for a legal funct3
   function automatic logic [2:0] f3_nbytes(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   return 3'd1;
         2'b01:   return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/lsu_mem_port_load_ext.sv
// lsu_load_ext: combinational sign/zero extension of right-justified raw
// load data according to funct3. Shared by the memory port and a future
// cache path.
module lsu_load_ext
   import lsu_defs::*;
(
   input  logic [2:0]  i_funct3,
   input  logic [31:0] i_raw,
   output logic [31:0] o_data
);

   // Select the extension form from funct3; words pass through
   always_comb begin
      o_data = i_raw;
      case (i_funct3)
         F3_B:    o_data = {{24{i_raw[7]}}, i_raw[7:0]};
         F3_BU:   o_data = {24'h000000, i_raw[7:0]};
         F3_H:    o_data = {{16{i_raw[15]}}, i_raw[15:0]};
         F3_HU:   o_data = {16'h0000, i_raw[15:0]};
         default: o_data = i_raw;
      endcase
   end

endmodule

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: single-outstanding load/store initiator for the unified
// memory data port. All state changes on negedge CLK; async active-low RST.
// Optional build macro MISALIGN_SPLIT_EN: misaligned half/word accesses
// are performed as a sequence of byte beats instead of faulting.
module lsu_mem_port
   import lsu_defs::*;
#(
   parameter int unsigned MEM_BYTES = 1024
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic [1:0]  rsp_err,
   output logic [31:0] DataAddr,
   output logic [1:0]  DataSize,
   output logic [31:0] DataIn,
   input  logic [31:0] DataOut,
   output logic        WE
);

   localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

   lsu_state_t  r_state, w_state_nxt;
   logic        r_we,    w_we_nxt;
   logic [2:0]  r_f3,    w_f3_nxt;
   logic [31:0] r_addr,  w_addr_nxt;
   logic [31:0] r_wdata, w_wdata_nxt;
   logic [31:0] r_rdata, w_rdata_nxt;
   logic [1:0]  r_err,   w_err_nxt;

   logic [2:0]  w_nbytes;
   logic        w_legal;
   logic        w_misal;
   logic        w_misal_fault;
   logic [32:0] w_last;
   logic        w_oor;
   logic [31:0] w_ext_raw;
   logic [31:0] w_ext_data;

`ifdef MISALIGN_SPLIT_EN
   logic        r_split, w_split_nxt;
   logic [1:0]  r_beat,  w_beat_nxt;
   logic [31:0] r_asm,   w_asm_nxt;
   logic [31:0] w_asm_merge;
   logic        w_last_beat;
`endif

   // Classify the incoming request: legality, alignment and 33-bit range check
   always_comb begin
      w_nbytes = f3_nbytes(req_funct3);
      w_legal  = f3_legal(req_we, req_funct3);
      w_misal  = ((req_funct3[1:0] == SZ_HALF) && req_addr[0]) ||
                 ((req_funct3[1:0] == SZ_WORD) && (req_addr[1:0] != 2'b00));
      w_last   = {1'b0, req_addr} + {30'b0, w_nbytes} - 33'd1;
      w_oor    = (w_last >= MEM_LIMIT);
`ifdef MISALIGN_SPLIT_EN
      w_misal_fault = 1'b0;
`else
      w_misal_fault = w_misal;
`endif
   end

`ifdef MISALIGN_SPLIT_EN
   // Merge this beat's byte into the assembly value and detect the final beat
   always_comb begin
      w_asm_merge = r_asm;
      w_asm_merge[{r_beat, 3'b000} +: 8] = DataOut[7:0];
      w_last_beat = (r_beat == ((r_f3[1:0] == SZ_HALF) ? 2'd1 : 2'd3));
   end

   // Split accesses extend the assembled bytes; single-beat ones use DataOut
   always_comb begin
      w_ext_raw = r_split ? w_asm_merge : DataOut;
   end
`else
   // Single-beat accesses extend the memory read data directly
   always_comb begin
      w_ext_raw = DataOut;
   end
`endif

   lsu_load_ext u_load_ext (
      .i_funct3 (r_f3),
      .i_raw    (w_ext_raw),
      .o_data   (w_ext_data)
   );

   // Next-state and next-register logic for the IDLE/ACC/RESP controller
   always_comb begin
      w_state_nxt = r_state;
      w_we_nxt    = r_we;
      w_f3_nxt    = r_f3;
      w_addr_nxt  = r_addr;
      w_wdata_nxt = r_wdata;
      w_rdata_nxt = r_rdata;
      w_err_nxt   = r_err;
`ifdef MISALIGN_SPLIT_EN
      w_split_nxt = r_split;
      w_beat_nxt  = r_beat;
      w_asm_nxt   = r_asm;
`endif
      case (r_state)
         ST_IDLE: begin
            if (req_valid) begin
               w_we_nxt    = req_we;
               w_f3_nxt    = req_funct3;
               w_addr_nxt  = req_addr;
               w_wdata_nxt = req_wdata;
               w_rdata_nxt = '0;
               if (!w_legal) begin
                  w_err_nxt   = ERR_FUNCT3;
                  w_state_nxt = ST_RESP;
               end else if (w_misal_fault) begin
                  w_err_nxt   = ERR_MISALIGN;
                  w_state_nxt = ST_RESP;
               end else if (w_oor) begin
                  w_err_nxt   = ERR_RANGE;
                  w_state_nxt = ST_RESP;
               end else begin
                  w_err_nxt   = ERR_OK;
                  w_state_nxt = ST_ACC;
`ifdef MISALIGN_SPLIT_EN
                  w_split_nxt = w_misal;
                  w_beat_nxt  = '0;
                  w_asm_nxt   = '0;
`endif
               end
            end
         end
         ST_ACC: begin
`ifdef MISALIGN_SPLIT_EN
            if (r_split) begin
               w_asm_nxt  = w_asm_merge;
               w_beat_nxt = r_beat + 2'd1;
               if (w_last_beat) begin
                  w_rdata_nxt = r_we ? '0 : w_ext_data;
                  w_state_nxt = ST_RESP;
               end
            end else begin
               w_rdata_nxt = r_we ? '0 : w_ext_data;
               w_state_nxt = ST_RESP;
            end
`else
            w_rdata_nxt = r_we ? '0 : w_ext_data;
            w_state_nxt = ST_RESP;
`endif
         end
         ST_RESP: begin
            if (rsp_ready)
               w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State and request registers, updated on the falling clock edge
   always_ff @(negedge CLK or negedge RST) begin
      if (!RST) begin
         r_state <= ST_IDLE;
         r_we    <= 1'b0;
         r_f3    <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_err   <= ERR_OK;
`ifdef MISALIGN_SPLIT_EN
         r_split <= 1'b0;
         r_beat  <= '0;
         r_asm   <= '0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_we    <= w_we_nxt;
         r_f3    <= w_f3_nxt;
         r_addr  <= w_addr_nxt;
         r_wdata <= w_wdata_nxt;
         r_rdata <= w_rdata_nxt;
         r_err   <= w_err_nxt;
`ifdef MISALIGN_SPLIT_EN
         r_split <= w_split_nxt;
         r_beat  <= w_beat_nxt;
         r_asm   <= w_asm_nxt;
`endif
      end
   end

   // Memory-side and handshake outputs decoded purely from registered state
   always_comb begin
      req_ready = (r_state == ST_IDLE);
      rsp_valid = (r_state == ST_RESP);
      rsp_rdata = r_rdata;
      rsp_err   = r_err;
      DataAddr  = '0;
      DataSize  = SZ_BYTE;
      DataIn    = '0;
      WE        = 1'b0;
      if (r_state == ST_ACC) begin
         DataAddr = r_addr;
         DataSize = r_f3[1:0];
         DataIn   = r_wdata;
         WE       = r_we;
`ifdef MISALIGN_SPLIT_EN
         if (r_split) begin
            DataAddr = r_addr + 32'(r_beat);
            DataSize = SZ_BYTE;
            DataIn   = {24'h000000, r_wdata[{r_beat, 3'b000} +: 8]};
         end
`endif
      end
   end

endmodule

// File: tb/tb_lsu_mem_port.sv
// tb_lsu_mem_port: randomized and directed checks of lsu_mem_port against a
// byte-array reference model. Build with MISALIGN_SPLIT_EN to cover the
// split-access variant.
module tb_lsu_mem_port;

   localparam int unsigned MEM_BYTES = 1024;
`ifdef MISALIGN_SPLIT_EN
   localparam bit SPLIT = 1'b1;
`else
   localparam bit SPLIT = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_err;
   logic [31:0] DataAddr;
   logic [1:0]  DataSize;
   logic [31:0] DataIn;
   logic [31:0] DataOut;
   logic        WE;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   logic [7:0]  mem     [MEM_BYTES];
   logic [7:0]  ref_mem [MEM_BYTES];
   logic [31:0] last_rdata;
   logic [1:0]  last_err;

   always #5 CLK = ~CLK;

   lsu_mem_port #(.MEM_BYTES(MEM_BYTES)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .DataAddr   (DataAddr),
      .DataSize   (DataSize),
      .DataIn     (DataIn),
      .DataOut    (DataOut),
      .WE         (WE)
   );

   function automatic logic [7:0] preset(input int unsigned i);
      case (i)
         32'h100: return 8'h80;
         32'h101: return 8'h7F;
         32'h102: return 8'h34;
         32'h103: return 8'h12;
         default: return 8'((i * 37 + 11) ^ (i >> 3));
      endcase
   endfunction

   function automatic logic [7:0] rd(input logic [31:0] a);
      if (a < MEM_BYTES) return mem[a[9:0]];
      return 8'h00;
   endfunction

   // Memory read port: byte replicated x4, half x2, word as is
   always_comb begin
      case (DataSize)
         2'b00:   DataOut = {4{rd(DataAddr)}};
         2'b01:   DataOut = {2{rd(DataAddr + 32'd1), rd(DataAddr)}};
         default: DataOut = {rd(DataAddr + 32'd3), rd(DataAddr + 32'd2),
                             rd(DataAddr + 32'd1), rd(DataAddr)};
      endcase
   end

   // Memory array: preset contents, then writes at negedge when WE
   initial begin
      for (int i = 0; i < int'(MEM_BYTES); i++) mem[i] = preset(i);
      forever begin
         @(negedge CLK);
         if (WE) begin
            for (int k = 0; k < 4; k++) begin
               if ((DataSize == 2'b00 && k < 1) || (DataSize == 2'b01 && k < 2) ||
                   (DataSize == 2'b10)) begin
                  if ({1'b0, DataAddr} + 33'(k) < 33'(MEM_BYTES))
                     mem[int'(DataAddr) + k] = DataIn[8*k +: 8];
               end
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int unsigned nbytes(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   return 1;
         2'b01:   return 2;
         default: return 4;
      endcase
   endfunction

   function automatic logic [1:0] model_err(input logic we, input logic [2:0] f3,
                                            input logic [31:0] addr);
      bit legal;
      longint unsigned a;
      int unsigned n;
      legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
      if (!legal) return 2'b10;
      n = nbytes(f3);
      if ((addr % n) != 0 && !SPLIT) return 2'b01;
      a = addr;
      if (a + n - 1 >= MEM_BYTES) return 2'b11;
      return 2'b00;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
      logic [63:0] v;
      int unsigned n;
      n = nbytes(f3);
      v = '0;
      for (int k = 0; k < int'(n); k++)
         v = v | (64'(ref_mem[int'(addr) + k]) << (8 * k));
      if (!f3[2] && n < 4 && v[8*n-1]) v = v | (~64'h0 << (8 * n));
      return v[31:0];
   endfunction

   task automatic model_store(input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata);
      int unsigned n;
      n = nbytes(f3);
      for (int k = 0; k < int'(n); k++)
         ref_mem[int'(addr) + k] = wdata[8*k +: 8];
   endtask

   // ---------------- transaction driver ----------------
   task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input int unsigned hold);
      logic [1:0]  e_err;
      logic [31:0] e_rdata;
      int unsigned n, e_lat, e_we, cyc, wecnt;
      logic [31:0] got_m, exp_m;
      n       = nbytes(f3);
      e_err   = model_err(we, f3, addr);
      e_lat   = (e_err != 2'b00) ? 0 : (((addr % n) != 0) ? n : 1);
      e_we    = (we && e_err == 2'b00) ? e_lat : 0;
      e_rdata = (e_err == 2'b00 && !we) ? model_load(f3, addr) : 32'h0;
      if (e_err == 2'b00 && we) model_store(f3, addr, wdata);

      check("req_ready_before", 32'(req_ready), 32'd1);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wdata;
      rsp_ready  = 1'b1;
      @(negedge CLK);
      @(posedge CLK); #1;
      req_valid  = 1'b0;
      req_we     = 1'($urandom);
      req_funct3 = 3'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;
      cyc   = 0;
      wecnt = 0;
      while (!rsp_valid && cyc < 16) begin
         if (WE) wecnt++;
         cyc++;
         @(posedge CLK); #1;
      end
      check("latency", cyc, e_lat);
      check("we_cycles", wecnt, e_we);
      check("rsp_rdata", rsp_rdata, e_rdata);
      check("rsp_err", 32'(rsp_err), 32'(e_err));
      check("req_ready_busy", 32'(req_ready), 32'd0);
      last_rdata = rsp_rdata;
      last_err   = rsp_err;
      if (hold > 0) begin
         rsp_ready  = 1'b0;
         req_valid  = 1'b1;
         req_we     = 1'b1;
         req_funct3 = 3'b010;
         req_addr   = {addr[31:2], 2'b00};
         req_wdata  = 32'h5A5A5A5A;
         for (int i = 0; i < int'(hold); i++) begin
            @(posedge CLK); #1;
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_rdata", rsp_rdata, e_rdata);
            check("hold_ready", 32'(req_ready), 32'd0);
         end
         req_valid = 1'b0;
         rsp_ready = 1'b1;
      end
      @(posedge CLK); #1;
      check("req_ready_after", 32'(req_ready), 32'd1);
      got_m = '0;
      exp_m = '0;
      for (int k = 0; k < 4; k++) begin
         if ({1'b0, addr} + 33'(k) < 33'(MEM_BYTES)) begin
            got_m[8*k +: 8] = mem[int'(addr) + k];
            exp_m[8*k +: 8] = ref_mem[int'(addr) + k];
         end
      end
      check("mem_bytes", got_m, exp_m);
   endtask

   task automatic reset_mid_store();
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = 3'b010;
      req_addr   = 32'h300;
      req_wdata  = 32'h11223344;
      @(negedge CLK);
      @(posedge CLK); #1;
      req_valid = 1'b0;
      check("rst_we_in_acc", 32'(WE), 32'd1);
      RST = 1'b0;
      #1;
      check("rst_we_drop", 32'(WE), 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_data_addr", DataAddr, 32'h0);
      check("rst_data_in", DataIn, 32'h0);
      check("rst_data_size", 32'(DataSize), 32'd0);
      @(posedge CLK); #1;
      RST = 1'b1;
      @(posedge CLK); #1;
      check("rst_release_ready", 32'(req_ready), 32'd1);
      check("rst_mem_untouched",
            {mem[32'h303], mem[32'h302], mem[32'h301], mem[32'h300]},
            {ref_mem[32'h303], ref_mem[32'h302], ref_mem[32'h301], ref_mem[32'h300]});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0]  f3;
      logic [31:0] addr;
      int unsigned sel, hold;
      logic [2:0]  legal_f3 [5];
      legal_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      for (int i = 0; i < int'(MEM_BYTES); i++) ref_mem[i] = preset(i);
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_funct3 = '0;
      req_addr   = '0;
      req_wdata  = '0;
      rsp_ready  = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      check("reset_req_ready", 32'(req_ready), 32'd1);
      check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset_rsp_rdata", rsp_rdata, 32'h0);
      check("reset_rsp_err", 32'(rsp_err), 32'd0);
      check("reset_we", 32'(WE), 32'd0);
      check("reset_data_addr", DataAddr, 32'h0);
      check("reset_data_size", 32'(DataSize), 32'd0);
      check("reset_data_in", DataIn, 32'h0);
      RST = 1'b1;
      @(posedge CLK); #1;

      do_txn(1'b0, 3'b000, 32'h100, 32'h0, 0);
      check("lb_const", last_rdata, 32'hFFFFFF80);
      do_txn(1'b0, 3'b100, 32'h100, 32'h0, 0);
      check("lbu_const", last_rdata, 32'h00000080);
      do_txn(1'b0, 3'b001, 32'h102, 32'h0, 0);
      check("lh_const", last_rdata, 32'h00001234);
      do_txn(1'b1, 3'b010, 32'h200, 32'hDEADBEEF, 0);
      do_txn(1'b0, 3'b010, 32'h200, 32'h0, 0);
      check("lw_const", last_rdata, 32'hDEADBEEF);
      do_txn(1'b1, 3'b001, 32'h201, 32'h0000ABCD, 0);
      check("sh_mis_err", 32'(last_err), SPLIT ? 32'd0 : 32'd1);
      do_txn(1'b0, 3'b011, 32'h100, 32'h0, 0);
      check("illegal_f3_const", 32'(last_err), 32'd2);
      do_txn(1'b0, 3'b010, 32'h3FE, 32'h0, 0);
      do_txn(1'b0, 3'b010, 32'hFFFFFFFC, 32'h0, 0);
      check("wrap_const", 32'(last_err), 32'd3);
      do_txn(1'b0, 3'b010, 32'h3FC, 32'h0, 0);
      do_txn(1'b0, 3'b010, 32'h100, 32'h0, 5);

      reset_mid_store();

      for (int t = 0; t < 300; t++) begin
         f3 = ($urandom_range(0, 9) < 9) ? legal_f3[$urandom_range(0, 4)] : 3'($urandom);
         sel = $urandom_range(0, 9);
         if (sel < 7)       addr = 32'($urandom_range(0, MEM_BYTES - 1));
         else if (sel == 7) addr = 32'(MEM_BYTES - 8) + 32'($urandom_range(0, 7));
         else if (sel == 8) addr = 32'hFFFFFFF0 | 32'($urandom_range(0, 15));
         else               addr = $urandom;
         hold = ($urandom_range(0, 9) > 7) ? $urandom_range(1, 3) : 0;
         do_txn(1'($urandom), f3, addr, $urandom, hold);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
